mem_arbiter: RTL and testbench

//  Shares the single-port word RAM between the instruction-fetch port and the

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin arbiter between the fetch and load/store ports of
//               a single-port word RAM; sequences setup / enable / capture.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SPACE = 9
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  i_req,
    input  logic [ADDR_SPACE-1:0] i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_SPACE-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  busy,
    output logic [ADDR_SPACE-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_datain,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic                  ram_enable,
    input  logic [DATA_WIDTH-1:0] ram_dataout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;      // 1: data port was granted last
    logic                  sel_q, sel_d;        // 1: data port owns the access
    logic [ADDR_SPACE-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_datain_q, ram_datain_d;
    logic                  ram_read_q, ram_read_d;
    logic                  ram_write_q, ram_write_d;
    logic                  ram_enable_q, ram_enable_d;
    logic                  i_ack_q, i_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  busy_q, busy_d;
    logic                  grant_data;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b0;
            sel_q        <= 1'b0;
            ram_addr_q   <= '0;
            ram_datain_q <= '0;
            ram_read_q   <= 1'b0;
            ram_write_q  <= 1'b0;
            ram_enable_q <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            sel_q        <= sel_d;
            ram_addr_q   <= ram_addr_d;
            ram_datain_q <= ram_datain_d;
            ram_read_q   <= ram_read_d;
            ram_write_q  <= ram_write_d;
            ram_enable_q <= ram_enable_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        sel_d        = sel_q;
        ram_addr_d   = ram_addr_q;
        ram_datain_d = ram_datain_q;
        ram_read_d   = ram_read_q;
        ram_write_d  = ram_write_q;
        ram_enable_d = ram_enable_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        // On a tie the port that did not win last time takes the grant.
        grant_data   = d_req && (!i_req || !last_q);

        case (state_q)
            S_IDLE: begin
                ram_enable_d = 1'b0;
                if (i_req || d_req) begin
                    sel_d        = grant_data;
                    last_d       = grant_data;
                    ram_addr_d   = grant_data ? d_addr : i_addr;
                    ram_datain_d = grant_data ? d_wdata : '0;
                    ram_read_d   = grant_data ? !d_we : 1'b1;
                    ram_write_d  = grant_data && d_we;
                    state_d      = S_SETUP;
                end else begin
                    ram_read_d  = 1'b0;
                    ram_write_d = 1'b0;
                end
            end
            S_SETUP: begin
                ram_enable_d = 1'b1;
                state_d      = S_STROBE;
            end
            S_STROBE: begin
                ram_enable_d = 1'b0;
                if (ram_read_q) begin
                    if (sel_q) d_rdata_d = ram_dataout;
                    else       i_rdata_d = ram_dataout;
                end
                if (sel_q) d_ack_d = 1'b1;
                else       i_ack_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                ram_read_d  = 1'b0;
                ram_write_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign i_ack      = i_ack_q;
    assign d_ack      = d_ack_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign busy       = busy_q;
    assign ram_addr   = ram_addr_q;
    assign ram_datain = ram_datain_q;
    assign ram_read   = ram_read_q;
    assign ram_write  = ram_write_q;
    assign ram_enable = ram_enable_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed self-checking bench with a behavioural RAM model.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 9;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_datain;
    logic          ram_read;
    logic          ram_write;
    logic          ram_enable;
    logic [DW-1:0] ram_dataout = '0;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_SPACE(AW)) dut (
        .clock(clock), .clear(clear),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
        .ram_addr(ram_addr), .ram_datain(ram_datain), .ram_read(ram_read),
        .ram_write(ram_write), .ram_enable(ram_enable), .ram_dataout(ram_dataout)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int en_pulses = 0;
    int i_acks    = 0;
    int d_acks    = 0;

    // RAM acts on the rising edge of its enable strobe.
    always @(posedge ram_enable) begin
        en_pulses++;
        if (ram_write) mem[ram_addr] = ram_datain;
        if (ram_read)  ram_dataout   = mem[ram_addr];
    end

    always @(negedge clock) begin
        if (i_ack) i_acks++;
        if (d_ack) d_acks++;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one request from idle; lat = edges from sampling edge to ack (1-based).
    task automatic access(input bit is_d, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output int lat);
        lat = -1;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock); #1;
            if (is_d ? d_ack : i_ack) begin
                lat = k;
                break;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    int  lat;
    int  p0;
    int  a0;
    int  n_got;
    int  t_ack [4];
    bit  who   [4];

    initial begin
        for (int k = 0; k < (1 << AW); k++) mem[k] = '0;
        mem[9'h075] = 32'd2;
        mem[9'h005] = 32'h69;
        mem[9'h048] = 32'h11;
        mem[9'h020] = 32'hAAAA_5555;
        mem[9'h030] = 32'hC0DE_0030;
        mem[9'h031] = 32'hDA7A_0031;
        mem[9'h1FF] = 32'hFFFF_01FF;

        // Reset, then idle ten cycles.
        repeat (2) @(negedge clock);
        clear = 1'b0;
        repeat (10) @(negedge clock);
        check("idle_ram_addr", 32'(ram_addr), 32'h0);
        check("idle_strobes", {29'd0, ram_read, ram_write, ram_enable}, 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_acks", 32'(i_acks + d_acks), 32'h0);
        check("idle_rdata", i_rdata | d_rdata, 32'h0);

        // Single fetch: cycle-by-cycle view.
        p0 = en_pulses;
        i_req = 1'b1; i_addr = 9'h075;
        @(posedge clock); #1;
        check("f_grant_busy", 32'(busy), 32'h1);
        check("f_grant_addr", 32'(ram_addr), 32'h75);
        check("f_grant_rw", {30'd0, ram_read, ram_write}, 32'h2);
        check("f_grant_en", 32'(ram_enable), 32'h0);
        @(posedge clock); #1;
        check("f_setup_en", 32'(ram_enable), 32'h1);
        check("f_setup_ack", 32'(i_ack), 32'h0);
        @(posedge clock); #1;
        check("f_ack", 32'(i_ack), 32'h1);
        check("f_rdata", i_rdata, 32'd2);
        check("f_en_low", 32'(ram_enable), 32'h0);
        i_req = 1'b0;
        @(posedge clock); #1;
        check("f_ack_pulse", 32'(i_ack), 32'h0);
        check("f_done_busy", 32'(busy), 32'h0);
        check("f_done_read", 32'(ram_read), 32'h0);
        check("f_en_pulses", 32'(en_pulses - p0), 32'd1);
        @(negedge clock);

        // Store then load back.
        access(1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF, lat);
        check("st_lat", 32'(lat), 32'd3);
        check("st_mem", mem[9'h010], 32'hDEAD_BEEF);
        check("st_d_rdata", d_rdata, 32'h0);
        access(1'b1, 1'b0, 9'h010, 32'h0, lat);
        check("ld_lat", 32'(lat), 32'd3);
        check("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("ld_i_rdata", i_rdata, 32'd2);

        // Top address passes through unchanged.
        access(1'b0, 1'b0, 9'h1FF, 32'h0, lat);
        check("top_rdata", i_rdata, 32'hFFFF_01FF);

        // Address changed after grant: latched copy is used.
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h005;
        @(posedge clock); #1;
        check("chg_grant_addr", 32'(ram_addr), 32'h5);
        @(negedge clock);
        d_addr = 9'h048;
        @(posedge clock); #1;
        check("chg_addr_held", 32'(ram_addr), 32'h5);
        @(posedge clock); #1;
        check("chg_ack", 32'(d_ack), 32'h1);
        check("chg_rdata", d_rdata, 32'h69);
        d_req = 1'b0;
        @(posedge clock);
        @(negedge clock);

        // Fresh reset, then both ports request continuously.
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        i_req = 1'b1; i_addr = 9'h030;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h031;
        n_got = 0;
        for (int c = 1; c <= 24 && n_got < 4; c++) begin
            @(posedge clock); #1;
            if (d_ack || i_ack) begin
                t_ack[n_got] = c;
                who[n_got]   = d_ack;
                n_got++;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check("rr_count", 32'(n_got), 32'd4);
        check("rr_order", {28'd0, who[0], who[1], who[2], who[3]}, 32'hA);
        check("rr_first_t", 32'(t_ack[0]), 32'd3);
        check("rr_gap1", 32'(t_ack[1] - t_ack[0]), 32'd4);
        check("rr_gap2", 32'(t_ack[2] - t_ack[1]), 32'd4);
        check("rr_gap3", 32'(t_ack[3] - t_ack[2]), 32'd4);
        check("rr_i_rdata", i_rdata, 32'hC0DE_0030);
        check("rr_d_rdata", d_rdata, 32'hDA7A_0031);
        repeat (4) @(negedge clock);

        // Reset during SETUP of a store.
        a0 = d_acks;
        p0 = en_pulses;
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h020; d_wdata = 32'h1234;
        @(posedge clock); #1;
        check("rst_in_setup", {30'd0, busy, ram_write}, 32'h3);
        clear = 1'b1;
        #2;
        check("rst_strobes", {29'd0, ram_read, ram_write, ram_enable}, 32'h0);
        check("rst_busy_addr", {busy, 22'd0, ram_addr}, 32'h0);
        check("rst_rdata", i_rdata | d_rdata | ram_datain, 32'h0);
        @(negedge clock);
        d_req = 1'b0;
        clear = 1'b0;
        repeat (6) @(negedge clock);
        check("rst_no_ack", 32'(d_acks - a0), 32'd0);
        check("rst_no_pulse", 32'(en_pulses - p0), 32'd0);
        check("rst_mem", mem[9'h020], 32'hAAAA_5555);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
